alu_seq: RTL

Parametrised, clocked successor to the combinational datapath ALU. It accepts one operation per valid/ready handshake and returns a registered result with registered flags. It adds carry-chained arithmetic (ADC/SBC), a logical right shift and an iterative shift-add multiplier. It sits between the register file read ports and the writeback mux, so the control FSM can stall on multi-cycle ops.

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_mul_iter.sv | 60 ++++++
 rtl/alu_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode, FSM state and width helpers for the sequential ALU.
package alu_seq_pkg;

    // The first twelve encodings are inherited from the combinational ALU.
    typedef enum logic [3:0] {
        NOP    = 4'd0,
        INC    = 4'd1,
        DEC    = 4'd2,
        CLB    = 4'd3,
        ADD    = 4'd4,
        SUB    = 4'd5,
        ORR    = 4'd6,
        AND    = 4'd7,
        XOR    = 4'd8,
        LSH    = 4'd9,
        RXOR_7 = 4'd10,
        RXOR_8 = 4'd11,
        MUL    = 4'd12,
        ADC    = 4'd13,
        SBC    = 4'd14,
        RSH    = 4'd15
    } op_mne;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        HOLD    = 2'd2
    } alu_seq_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Operation request / result bundle between the register-file read ports, the ALU and writeback.
interface alu_seq_if #(
    parameter int W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    alu_seq_pkg::op_mne   op;
    logic [W-1:0]         A;
    logic [W-1:0]         B;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         Out;
    logic [W-1:0]         Hi;
    logic                 Zero;
    logic                 Carry;
    logic                 Neg;
    logic                 Ovf;
    logic                 busy;

    modport master (
        output in_valid, op, A, B, out_ready,
        input  in_ready, out_valid, Out, Hi, Zero, Carry, Neg, Ovf, busy
    );

    modport slave (
        input  in_valid, op, A, B, out_ready,
        output in_ready, out_valid, Out, Hi, Zero, Carry, Neg, Ovf, busy
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier, W cycles from start to done; operands latched on start.
// No backpressure: done is a one-cycle pulse and product is only meaningful while done=1.
module alu_mul_iter #(
    parameter int W  = 8,
    parameter int CW = $clog2(W) + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [2*W:0]   prod_q, prod_d;
    logic [2*W:0]   step;
    logic [2*W:0]   prod_shift;

    // Upper W+1 bits accumulate, lower W bits hold the remaining multiplier bits.
    always_comb begin
        step = prod_q;
        if (prod_q[0]) begin
            step[2*W:W] = prod_q[2*W:W] + {1'b0, mcand_q};
        end
        prod_shift = step >> 1;
    end

    always_comb begin
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        if (start) begin
            cnt_d   = CW'(W);
            mcand_d = a;
            prod_d  = {{(W+1){1'b0}}, b};
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - 1'b1;
            prod_d = prod_shift;
        end
    end

    // The last iteration's result is handed out combinationally so the caller can
    // register it on the W-th edge after start.
    assign done    = (cnt_q == CW'(1));
    assign product = prod_shift[2*W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle ops valid 1 cycle after accept, MUL exactly W cycles after accept.
// Result is held while out_ready=0; a new op is accepted in the same edge the old result is consumed.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W) + 1
) (
    input  logic    clk,
    input  logic    reset,
    alu_seq_if.slave bus
);
    localparam logic [W-1:0] W_LIM = W[W-1:0];

    alu_seq_state_e state_q, state_d;
    logic [W-1:0]   out_q, out_d;
    logic [W-1:0]   hi_q, hi_d;
    logic           zero_q, zero_d;
    logic           carry_q, carry_d;
    logic           neg_q, neg_d;
    logic           ovf_q, ovf_d;

    logic [W-1:0]   a, b;
    logic           accept;
    logic           mul_start;
    logic           mul_done;
    logic [2*W-1:0] mul_product;

    logic [W:0]     sum;
    logic [W-1:0]   res;
    logic           c_res;
    logic           ovf_res;
    logic           legal;

    assign a = bus.A;
    assign b = bus.B;

    assign bus.in_ready  = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.busy      = (state_q == MUL_RUN);
    assign bus.Out       = out_q;
    assign bus.Hi        = hi_q;
    assign bus.Zero      = zero_q;
    assign bus.Carry     = carry_q;
    assign bus.Neg       = neg_q;
    assign bus.Ovf       = ovf_q;

    // Single-cycle datapath; c_res defaults to the held carry for ops that leave it alone.
    always_comb begin
        sum     = '0;
        res     = '0;
        c_res   = carry_q;
        ovf_res = 1'b0;
        legal   = 1'b1;
        case (bus.op)
            NOP: res = a;
            INC: begin
                sum     = {1'b0, a} + {{W{1'b0}}, 1'b1};
                res     = sum[W-1:0];
                c_res   = sum[W];
                ovf_res = ~a[W-1] & res[W-1];
            end
            DEC: begin
                sum     = {1'b0, a} - {{W{1'b0}}, 1'b1};
                res     = sum[W-1:0];
                c_res   = |a;
                ovf_res = a[W-1] & ~res[W-1];
            end
            CLB: begin
                res        = a;
                res[W-1]   = 1'b0;
            end
            ADD, ADC: begin
                sum     = {1'b0, a} + {1'b0, b}
                        + {{W{1'b0}}, (bus.op == ADC) ? carry_q : 1'b0};
                res     = sum[W-1:0];
                c_res   = sum[W];
                ovf_res = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
            end
            SUB, SBC: begin
                // A - B - !C == A + ~B + C; SUB is the C=1 case.
                sum     = {1'b0, a} + {1'b0, ~b}
                        + {{W{1'b0}}, (bus.op == SBC) ? carry_q : 1'b1};
                res     = sum[W-1:0];
                c_res   = sum[W];
                ovf_res = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
            end
            ORR:    res = a | b;
            AND:    res = a & b;
            XOR:    res = a ^ b;
            LSH:    res = (b >= W_LIM) ? '0 : (a << b);
            RSH:    res = (b >= W_LIM) ? '0 : (a >> b);
            RXOR_7: res = {{(W-1){1'b0}}, ^a[W-2:0]};
            RXOR_8: res = {{(W-1){1'b0}}, ^a};
            MUL:    res = '0;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        hi_d      = hi_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        mul_start = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
                    if (bus.op == MUL) begin
                        mul_start = 1'b1;
                        state_d   = MUL_RUN;
                    end else begin
                        state_d = HOLD;
                        hi_d    = '0;
                        if (legal) begin
                            out_d   = res;
                            zero_d  = (res == '0);
                            carry_d = c_res;
                            neg_d   = res[W-1];
                            ovf_d   = ovf_res;
                        end else begin
                            out_d  = '0;
                            zero_d = 1'b1;
                        end
                    end
                end else if (state_q == HOLD && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            MUL_RUN: begin
                if (mul_done) begin
                    state_d = HOLD;
                    out_d   = mul_product[W-1:0];
                    hi_d    = mul_product[2*W-1:W];
                    zero_d  = (mul_product[W-1:0] == '0);
                    carry_d = |mul_product[2*W-1:W];
                    neg_d   = mul_product[W-1];
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    alu_mul_iter #(
        .W  (W),
        .CW (CW)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            out_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
